// File: rtl/snake_pkg.sv
// Shared snake-game definitions: the playfield window for food placement,
// the pixel colour type and the food spawner's state encoding.
package snake_pkg;

  typedef logic [2:0] colour_t;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    QUERY,
    WAIT_OCC,
    ERASE,
    DRAW,
    DONE
  } spawn_state_t;

  // Food may only land inside this window; border cells are reserved.
  localparam logic [7:0] X_MIN = 8'd1;
  localparam logic [7:0] X_MAX = 8'd158;
  localparam logic [6:0] Y_MIN = 7'd1;
  localparam logic [6:0] Y_MAX = 7'd118;

  function automatic logic in_window(input logic [7:0] x, input logic [6:0] y);
    return (x >= X_MIN) && (x <= X_MAX) && (y >= Y_MIN) && (y <= Y_MAX);
  endfunction

endpackage

// File: rtl/food_spawner.sv
// Food spawner: on request, draws random candidate positions, rejects border
// cells and cells occupied by the snake, then erases the old food pixel and
// draws the new one. Gives up after MAX_TRIES rejected candidates.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   spawn_req               start a spawn (sampled in IDLE only)
//   rng_posX, rng_posY      random candidate coordinate
//   occ_req, occ_x, occ_y   occupancy query to the snake-body checker
//   occ_ack, occ_hit        checker response (hit qualified by ack)
//   food_x, food_y          current food position
//   food_valid              a food has been placed
//   spawn_busy              high whenever not in IDLE
//   spawn_done, spawn_fail  one-cycle completion / give-up pulses
//   vga_x, vga_y,
//   vga_colour, vga_plot    pixel write port
module food_spawner
  import snake_pkg::*;
#(
  parameter int unsigned MAX_TRIES   = 16,
  parameter colour_t     FOOD_COLOUR = 3'b010,
  parameter colour_t     BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spawn_req,
  input  logic [7:0] rng_posX,
  input  logic [6:0] rng_posY,
  output logic       occ_req,
  output logic [7:0] occ_x,
  output logic [6:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [7:0] food_x,
  output logic [6:0] food_y,
  output logic       food_valid,
  output logic       spawn_busy,
  output logic       spawn_done,
  output logic       spawn_fail,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output colour_t    vga_colour,
  output logic       vga_plot
);

  localparam int unsigned     TW        = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]   TRY_LIMIT = TW'(MAX_TRIES);

  spawn_state_t  state;
  logic [TW-1:0] tries;
  logic [TW-1:0] tries_inc;
  logic [7:0]    cand_x;
  logic [6:0]    cand_y;

  // Saturating increment so the counter can never wrap back below the limit.
  always_comb begin
    tries_inc = tries;
    if (tries != TRY_LIMIT) tries_inc = tries + TW'(1);
  end

  // The candidate register doubles as the query coordinate; it is only
  // reloaded in SAMPLE, so it is stable for the whole of WAIT_OCC.
  assign occ_x = cand_x;
  assign occ_y = cand_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tries      <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      spawn_busy <= 1'b0;
      spawn_done <= 1'b0;
      spawn_fail <= 1'b0;
      occ_req    <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      // Strobes are high only in the cycle after the transition that sets them.
      occ_req    <= 1'b0;
      vga_plot   <= 1'b0;
      spawn_done <= 1'b0;
      spawn_fail <= 1'b0;
      unique case (state)
        IDLE: begin
          if (spawn_req) begin
            state      <= SAMPLE;
            tries      <= '0;
            spawn_busy <= 1'b1;
          end
        end
        SAMPLE: begin
          cand_x <= rng_posX;
          cand_y <= rng_posY;
          tries  <= tries_inc;
          // Window check is done on the live RNG value so that a border
          // candidate costs a single cycle and never reaches the checker.
          if (in_window(rng_posX, rng_posY)) begin
            state   <= QUERY;
            occ_req <= 1'b1;
          end else if (tries_inc == TRY_LIMIT) begin
            state      <= IDLE;
            spawn_fail <= 1'b1;
            spawn_busy <= 1'b0;
          end
        end
        QUERY: begin
          state <= WAIT_OCC;
        end
        WAIT_OCC: begin
          if (occ_ack) begin
            if (occ_hit) begin
              if (tries == TRY_LIMIT) begin
                state      <= IDLE;
                spawn_fail <= 1'b1;
                spawn_busy <= 1'b0;
              end else begin
                state <= SAMPLE;
              end
            end else if (food_valid) begin
              state      <= ERASE;
              vga_plot   <= 1'b1;
              vga_x      <= food_x;
              vga_y      <= food_y;
              vga_colour <= BG_COLOUR;
            end else begin
              state      <= DRAW;
              vga_plot   <= 1'b1;
              vga_x      <= cand_x;
              vga_y      <= cand_y;
              vga_colour <= FOOD_COLOUR;
            end
          end
        end
        ERASE: begin
          state      <= DRAW;
          vga_plot   <= 1'b1;
          vga_x      <= cand_x;
          vga_y      <= cand_y;
          vga_colour <= FOOD_COLOUR;
        end
        DRAW: begin
          food_x     <= cand_x;
          food_y     <= cand_y;
          state      <= DONE;
          spawn_done <= 1'b1;
        end
        DONE: begin
          food_valid <= 1'b1;
          state      <= IDLE;
          spawn_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          spawn_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
